miriscv_execute_unit: RTL and testbench
=======================================

// Module: miriscv_execute_unit
// PURPOSE
//  Parametrised execute stage: ALU result in one cycle plus a built-in iterative multiply/divide FSM
//  (RV32M/RV64M semantics) with a stall handshake, resolving branches/jumps in EX. The registered
//  EX/MEM payload goes to the memory stage; a combinational bypass goes to the decode forwarding mux.
// PARAMETERS
//  XLEN          32  datapath width (32 or 64)
//  GPR_ADDR_W    5   register-file address width
//  MUL_BITS_CYC  2   multiplier bits retired per cycle; must divide XLEN (1,2,4,8)
// PORTS
//  clk_i             in   1           clock, rising edge
//  arst_i            in   1           asynchronous reset, active-high
//  cu_kill_e_i       in   1           flush EX: drop payload, abort MDU
//  cu_stall_e_i      in   1           hold EX/MEM register and MDU DONE state
//  e_stall_req_o     out  1           MDU busy; CU must stall upstream stages
//  d_valid_i         in   1           decode payload valid
//  d_op1_i,d_op2_i   in   XLEN        operands
//  d_alu_operation_i in   ALU_OP_W    ALU opcode (miriscv_alu encoding)
//  d_mdu_req_i       in   1           instruction is M-extension
//  d_mdu_operation_i in   3           funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU = 0..7
//  d_gpr_wr_en_i     in   1           writeback enable
//  d_gpr_wr_addr_i   in   GPR_ADDR_W  destination register
//  d_branch_i,d_jump_i in 1           conditional branch / JAL-JALR
//  d_prediction_i    in   1           fetch predicted taken
//  d_target_pc_i     in   XLEN        resolved target PC
//  e_valid_o         out  1           EX/MEM payload valid
//  e_result_o        out  XLEN        registered ALU or MDU result
//  e_gpr_wr_en_o     out  1           registered writeback enable
//  e_gpr_wr_addr_o   out  GPR_ADDR_W  registered destination
//  e_br_j_taken_o    out  1           registered taken (jump | branch&cond)
//  e_mispredict_o    out  1           registered e_br_j_taken_o != prediction, for branch|jump
//  e_target_pc_o     out  XLEN        registered target PC
//  e_byp_data_o      out  XLEN        combinational: MDU result in DONE, else ALU result
// BEHAVIOUR
//  - Reset: all registered outputs 0, FSM IDLE, e_stall_req_o 0.
//  - ALU path: capture on edge when d_valid_i & ~d_mdu_req_i & ~cu_stall_e_i; latency 1.
//  - MDU FSM IDLE->MUL|DIV->DONE->IDLE. Accept = IDLE & d_valid_i & d_mdu_req_i & ~cu_kill_e_i;
//    operands latched, cnt=0, e_stall_req_o=1 combinationally in the accept cycle.
//  - MUL: XLEN/MUL_BITS_CYC cycles of shift-add on 2*XLEN product (sign-corrected per op);
//    DIV: XLEN cycles restoring, 1 quotient bit/cycle, on magnitudes, sign fixed in DONE.
//    Last cycle (cnt==N-1) -> DONE. e_stall_req_o=1 in accept and MUL/DIV states, 0 in DONE.
//  - DONE: result on e_byp_data_o; captured into e_result_o, e_valid_o=1 on the first edge
//    with ~cu_stall_e_i, then IDLE. cu_stall_e_i high holds DONE and the result.
//  - While e_stall_req_o=1 the EX/MEM register loads e_valid_o=0 (bubble) unless cu_stall_e_i.
//  - MUL 32b, MUL_BITS_CYC=2: stall 17 cycles (accept+16); result registered on 18th edge.
//  - Div-by-zero: quotient all-ones, remainder = dividend. Overflow (-2^(XLEN-1)/-1):
//    quotient = dividend, remainder 0. MULH* take upper XLEN bits, MUL lower.
//  - cu_kill_e_i: FSM->IDLE, e_valid_o=0 next edge, e_stall_req_o=0 next cycle; kill
//    beats accept and stall in the same cycle. Reset mid-operation: FSM IDLE, no result.
//  - New MDU request in DONE is not accepted until IDLE (CU stall covers it).
//  - e_mispredict_o=0 when neither branch nor jump.
// CONFIGURATION
//  MIRISCV_MDU_EARLY_OUT_EN defined: DIV/REM with divisor 0 or overflow operands skip iteration,
//  accept->DONE next cycle (stall 1 cycle). Undefined: full XLEN iterations, same results.
// TESTING
//  ADD 5+7, no stall -> e_result_o=12, e_valid_o=1 one edge later, e_stall_req_o never high.
//  MUL 0xFFFFFFFF*2 (MULHU) -> stall 17 cycles, e_result_o=0x00000001; MUL -> 0xFFFFFFFE.
//  DIV -7/2 -> -3, REM -> -1; DIVU 100/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0; check stall length both macro settings.
//  Kill at MUL cycle 5 -> stall low next cycle, e_valid_o=0; following ADD completes in 1 cycle.
//  DONE with cu_stall_e_i=1 for 3 cycles -> result held, captured once after release.
//  BEQ taken, prediction 0 -> e_br_j_taken_o=1, e_mispredict_o=1; arst_i mid-DIV -> all outputs 0.

Source files
------------

// File: rtl/miriscv_execute_unit_if.sv
// miriscv_execute_unit_if: decode payload, control-unit handshake and EX/MEM outputs of the execute stage
interface miriscv_execute_unit_if #(
  parameter int XLEN       = 32,
  parameter int GPR_ADDR_W = 5,
  parameter int ALU_OP_W   = 5
);
  logic                  cu_kill_e;
  logic                  cu_stall_e;
  logic                  e_stall_req;
  logic                  d_valid;
  logic [XLEN-1:0]       d_op1;
  logic [XLEN-1:0]       d_op2;
  logic [ALU_OP_W-1:0]   d_alu_operation;
  logic                  d_mdu_req;
  logic [2:0]            d_mdu_operation;
  logic                  d_gpr_wr_en;
  logic [GPR_ADDR_W-1:0] d_gpr_wr_addr;
  logic                  d_branch;
  logic                  d_jump;
  logic                  d_prediction;
  logic [XLEN-1:0]       d_target_pc;
  logic                  e_valid;
  logic [XLEN-1:0]       e_result;
  logic                  e_gpr_wr_en;
  logic [GPR_ADDR_W-1:0] e_gpr_wr_addr;
  logic                  e_br_j_taken;
  logic                  e_mispredict;
  logic [XLEN-1:0]       e_target_pc;
  logic [XLEN-1:0]       e_byp_data;
  modport master (
    output cu_kill_e, cu_stall_e, d_valid, d_op1, d_op2, d_alu_operation, d_mdu_req, d_mdu_operation,
           d_gpr_wr_en, d_gpr_wr_addr, d_branch, d_jump, d_prediction, d_target_pc,
    input  e_stall_req, e_valid, e_result, e_gpr_wr_en, e_gpr_wr_addr, e_br_j_taken, e_mispredict,
           e_target_pc, e_byp_data
  );
  modport slave (
    input  cu_kill_e, cu_stall_e, d_valid, d_op1, d_op2, d_alu_operation, d_mdu_req, d_mdu_operation,
           d_gpr_wr_en, d_gpr_wr_addr, d_branch, d_jump, d_prediction, d_target_pc,
    output e_stall_req, e_valid, e_result, e_gpr_wr_en, e_gpr_wr_addr, e_br_j_taken, e_mispredict,
           e_target_pc, e_byp_data
  );
endinterface

// File: rtl/miriscv_execute_unit.sv
// miriscv_execute_unit: single-cycle ALU plus iterative RV32M/RV64M mul/div with stall handshake; MIRISCV_MDU_EARLY_OUT_EN skips div iteration on divide-by-zero/overflow
module miriscv_execute_unit #(
  parameter int XLEN         = 32,
  parameter int GPR_ADDR_W   = 5,
  parameter int MUL_BITS_CYC = 2,
  parameter int ALU_OP_W     = 5
) (
  input logic clk_i,
  input logic arst_i,
  miriscv_execute_unit_if.slave ex
);
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'b01101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_LTS  = 5'b11100;
  localparam logic [ALU_OP_W-1:0] ALU_LTU  = 5'b11110;
  localparam logic [ALU_OP_W-1:0] ALU_GES  = 5'b11101;
  localparam logic [ALU_OP_W-1:0] ALU_GEU  = 5'b11111;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 5'b11000;
  localparam logic [ALU_OP_W-1:0] ALU_NE   = 5'b11001;
  localparam logic [ALU_OP_W-1:0] ALU_SLTS = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'b00011;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_BITS_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_e;
  mdu_state_e state_q, state_d;
  logic [XLEN-1:0] a, b, alu_res, a_mag, b_mag, quo, rem, mdu_res, opa_q, mplier_q;
  logic [CNT_W-1:0] shamt, cnt_q;
  logic [2:0] op, op_q;
  logic in_div, sa, sb, a_neg, b_neg, in_zero, in_ovf, early, accept, taken;
  logic neg_res_q, neg_rem_q, zero_q, ovf_q, mdu_wr_en_q;
  logic [GPR_ADDR_W-1:0] mdu_wr_addr_q;
  logic [2*XLEN-1:0] prod_q, mcand_q, prod_fix;
  logic [XLEN:0] rem_sh, diff;
  assign a = ex.d_op1;
  assign b = ex.d_op2;
  assign shamt = b[CNT_W-1:0];
  // ALU: arithmetic, logic, shifts and compares; compares yield a 0/1 result that also resolves branches
  always_comb begin
    case (ex.d_alu_operation)
      ALU_ADD:          alu_res = a + b;
      ALU_SUB:          alu_res = a - b;
      ALU_XOR:          alu_res = a ^ b;
      ALU_OR:           alu_res = a | b;
      ALU_AND:          alu_res = a & b;
      ALU_SLL:          alu_res = a << shamt;
      ALU_SRL:          alu_res = a >> shamt;
      ALU_SRA:          alu_res = $signed(a) >>> shamt;
      ALU_SLTS, ALU_LTS: alu_res = XLEN'($signed(a) < $signed(b));
      ALU_SLTU, ALU_LTU: alu_res = XLEN'(a < b);
      ALU_GES:          alu_res = XLEN'($signed(a) >= $signed(b));
      ALU_GEU:          alu_res = XLEN'(a >= b);
      ALU_EQ:           alu_res = XLEN'(a == b);
      ALU_NE:           alu_res = XLEN'(a != b);
      default:          alu_res = '0;
    endcase
  end
  assign taken = ex.d_jump | (ex.d_branch & alu_res[0]);
  assign op = ex.d_mdu_operation;
  assign in_div = op[2];
  assign sa = in_div ? ~op[0] : (op == 3'd1 || op == 3'd2);
  assign sb = in_div ? ~op[0] : (op == 3'd1);
  assign a_neg = sa & a[XLEN-1];
  assign b_neg = sb & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign in_zero = b == '0;
  assign in_ovf = in_div & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
`ifdef MIRISCV_MDU_EARLY_OUT_EN
  assign early = in_div & (in_zero | in_ovf);
`else
  assign early = 1'b0;
`endif
  assign accept = state_q == IDLE & ex.d_valid & ex.d_mdu_req & ~ex.cu_kill_e;
  assign ex.e_stall_req = accept | state_q == MUL | state_q == DIV;
  // MDU next state: kill wins, then accept, iteration end, and DONE release once the CU stops stalling
  always_comb begin
    state_d = ex.cu_kill_e ? IDLE :
              accept ? (early ? DONE : in_div ? DIV : MUL) :
              (state_q == MUL && cnt_q == MUL_LAST) ? DONE :
              (state_q == DIV && cnt_q == DIV_LAST) ? DONE :
              (state_q == DONE && !ex.cu_stall_e) ? IDLE : state_q;
  end
  // MDU state register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // One restoring-division step: shift the next dividend bit into the partial remainder and try to subtract
  assign rem_sh = {prod_q[XLEN-1:0], mplier_q[XLEN-1]};
  assign diff = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
  // MDU datapath: latch magnitudes on accept, then shift-add (multiply) or restoring steps (divide)
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      {op_q, opa_q, neg_res_q, neg_rem_q, zero_q, ovf_q, cnt_q} <= '0;
      {prod_q, mcand_q, mplier_q, mdu_wr_en_q, mdu_wr_addr_q} <= '0;
    end else if (accept) begin
      op_q <= op;
      opa_q <= a;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      zero_q <= in_zero;
      ovf_q <= in_ovf;
      cnt_q <= '0;
      prod_q <= '0;
      mcand_q <= {{XLEN{1'b0}}, in_div ? b_mag : a_mag};
      mplier_q <= in_div ? a_mag : b_mag;
      mdu_wr_en_q <= ex.d_gpr_wr_en;
      mdu_wr_addr_q <= ex.d_gpr_wr_addr;
    end else if (state_q == MUL) begin
      prod_q <= prod_q + mcand_q * {{(2*XLEN-MUL_BITS_CYC){1'b0}}, mplier_q[MUL_BITS_CYC-1:0]};
      mcand_q <= mcand_q << MUL_BITS_CYC;
      mplier_q <= mplier_q >> MUL_BITS_CYC;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == DIV) begin
      prod_q <= {{XLEN{1'b0}}, diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]};
      mplier_q <= {mplier_q[XLEN-2:0], ~diff[XLEN]};
      cnt_q <= cnt_q + 1'b1;
    end
  end
  // Sign correction and the RISC-V special cases for divide-by-zero and signed overflow
  assign prod_fix = neg_res_q ? -prod_q : prod_q;
  assign quo = zero_q ? '1 : ovf_q ? opa_q : neg_res_q ? -mplier_q : mplier_q;
  assign rem = zero_q ? opa_q : ovf_q ? '0 : neg_rem_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
  assign mdu_res = !op_q[2] ? (op_q[1:0] == 2'd0 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]) :
                   op_q[1] ? rem : quo;
  assign ex.e_byp_data = state_q == DONE ? mdu_res : alu_res;
  // EX/MEM register: kill clears, CU stall holds, MDU result in DONE, bubble while stalling, else ALU payload
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      {ex.e_valid, ex.e_result, ex.e_gpr_wr_en, ex.e_gpr_wr_addr} <= '0;
      {ex.e_br_j_taken, ex.e_mispredict, ex.e_target_pc} <= '0;
    end else if (ex.cu_kill_e) begin
      {ex.e_valid, ex.e_gpr_wr_en, ex.e_br_j_taken, ex.e_mispredict} <= '0;
    end else if (!ex.cu_stall_e) begin
      if (state_q == DONE) begin
        ex.e_valid <= 1'b1;
        ex.e_result <= mdu_res;
        ex.e_gpr_wr_en <= mdu_wr_en_q;
        ex.e_gpr_wr_addr <= mdu_wr_addr_q;
        {ex.e_br_j_taken, ex.e_mispredict} <= '0;
      end else if (ex.e_stall_req || !ex.d_valid) begin
        {ex.e_valid, ex.e_gpr_wr_en, ex.e_br_j_taken, ex.e_mispredict} <= '0;
      end else begin
        ex.e_valid <= 1'b1;
        ex.e_result <= alu_res;
        ex.e_gpr_wr_en <= ex.d_gpr_wr_en;
        ex.e_gpr_wr_addr <= ex.d_gpr_wr_addr;
        ex.e_br_j_taken <= taken;
        ex.e_mispredict <= (ex.d_branch | ex.d_jump) & (taken != ex.d_prediction);
        ex.e_target_pc <= ex.d_target_pc;
      end
    end
  end
endmodule

// File: tb/tb_miriscv_execute_unit.sv
// tb_miriscv_execute_unit: directed checks of ALU, MDU timing/results, kill, CU stall, branches and reset
module tb_miriscv_execute_unit;
  logic clk = 1'b0;
  logic arst = 1'b1;
  int total = 0;
  int bad = 0;
  int n;
  always #5 clk = ~clk;
`ifdef MIRISCV_MDU_EARLY_OUT_EN
  localparam int SPECIAL_STALL = 1;
`else
  localparam int SPECIAL_STALL = 33;
`endif
  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b01000, XOR = 5'b00100, SRA = 5'b01101;
  localparam logic [4:0] SLTU = 5'b00011, EQ = 5'b11000, NE = 5'b11001;
  miriscv_execute_unit_if #(.XLEN(32), .GPR_ADDR_W(5), .ALU_OP_W(5)) ex ();
  miriscv_execute_unit #(.XLEN(32), .GPR_ADDR_W(5), .MUL_BITS_CYC(2), .ALU_OP_W(5)) dut (
    .clk_i(clk), .arst_i(arst), .ex(ex)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle_in();
    ex.cu_kill_e = 0; ex.cu_stall_e = 0; ex.d_valid = 0; ex.d_op1 = 0; ex.d_op2 = 0;
    ex.d_alu_operation = 0; ex.d_mdu_req = 0; ex.d_mdu_operation = 0; ex.d_gpr_wr_en = 0;
    ex.d_gpr_wr_addr = 0; ex.d_branch = 0; ex.d_jump = 0; ex.d_prediction = 0; ex.d_target_pc = 0;
  endtask
  task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    idle_in();
    ex.d_valid = 1; ex.d_alu_operation = op; ex.d_op1 = a; ex.d_op2 = b;
    ex.d_gpr_wr_en = 1; ex.d_gpr_wr_addr = 5'd7;
  endtask
  task automatic alu_check(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    alu(op, a, b);
    #1;
    chk({tag, "_nostall"}, ex.e_stall_req, 0);
    cyc();
    chk({tag, "_res"}, ex.e_result, exp);
    chk({tag, "_valid"}, ex.e_valid, 1);
    idle_in();
  endtask
  task automatic mdu_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cnt);
    idle_in();
    ex.d_valid = 1; ex.d_mdu_req = 1; ex.d_mdu_operation = op; ex.d_op1 = a; ex.d_op2 = b;
    ex.d_gpr_wr_en = 1; ex.d_gpr_wr_addr = 5'd9;
    #1;
    cnt = 0;
    while (ex.e_stall_req && cnt < 100) begin
      cnt++;
      cyc();
      ex.d_valid = 0; ex.d_mdu_req = 0;
      #1;
    end
  endtask
  task automatic mdu_check(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_stall);
    int c;
    mdu_run(op, a, b, c);
    chk({tag, "_stall"}, c, exp_stall);
    chk({tag, "_byp"}, ex.e_byp_data, exp);
    chk({tag, "_bubble"}, ex.e_valid, 0);
    cyc();
    chk({tag, "_res"}, ex.e_result, exp);
    chk({tag, "_valid"}, ex.e_valid, 1);
    chk({tag, "_addr"}, ex.e_gpr_wr_addr, 9);
  endtask
  initial begin
    idle_in();
    repeat (2) cyc();
    chk("rst_valid", ex.e_valid, 0);
    chk("rst_result", ex.e_result, 0);
    chk("rst_stall", ex.e_stall_req, 0);
    chk("rst_taken", ex.e_br_j_taken, 0);
    chk("rst_mispred", ex.e_mispredict, 0);
    chk("rst_target", ex.e_target_pc, 0);
    chk("rst_wr_en", ex.e_gpr_wr_en, 0);
    arst = 0;
    cyc();
    alu_check("add", ADD, 32'd5, 32'd7, 32'd12);
    chk("add_stall_after", ex.e_stall_req, 0);
    chk("add_addr", ex.e_gpr_wr_addr, 7);
    cyc();
    chk("add_drop", ex.e_valid, 0);
    alu_check("sub", SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_check("xor", XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    alu_check("sra", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_check("sltu", SLTU, 32'd3, 32'd5, 32'd1);
    mdu_check("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 17);
    mdu_check("mul", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 17);
    mdu_check("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17);
    mdu_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17);
    mdu_check("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    mdu_check("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    mdu_check("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    mdu_check("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    mdu_check("divu0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, SPECIAL_STALL);
    mdu_check("remu0", 3'd7, 32'd100, 32'd0, 32'd100, SPECIAL_STALL);
    mdu_check("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_STALL);
    mdu_check("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_STALL);
    idle_in();
    ex.d_valid = 1; ex.d_mdu_req = 1; ex.d_mdu_operation = 3'd0; ex.d_op1 = 3; ex.d_op2 = 3;
    #1;
    chk("kill_accept_stall", ex.e_stall_req, 1);
    cyc();
    idle_in();
    repeat (5) cyc();
    ex.cu_kill_e = 1;
    #1;
    chk("kill_cycle_stall", ex.e_stall_req, 1);
    cyc();
    ex.cu_kill_e = 0;
    #1;
    chk("kill_stall_low", ex.e_stall_req, 0);
    chk("kill_valid", ex.e_valid, 0);
    alu_check("kill_add", ADD, 32'd1, 32'd2, 32'd3);
    mdu_run(3'd0, 32'd6, 32'd7, n);
    chk("hold_stall", n, 17);
    ex.cu_stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_byp", ex.e_byp_data, 42);
      chk("hold_valid", ex.e_valid, 0);
      chk("hold_no_req", ex.e_stall_req, 0);
    end
    ex.cu_stall_e = 0;
    cyc();
    chk("hold_res", ex.e_result, 42);
    chk("hold_cap", ex.e_valid, 1);
    cyc();
    chk("hold_once", ex.e_valid, 0);
    alu(EQ, 32'd9, 32'd9);
    ex.d_branch = 1; ex.d_target_pc = 32'h100; ex.d_gpr_wr_en = 0;
    cyc();
    chk("beq_taken", ex.e_br_j_taken, 1);
    chk("beq_mispred", ex.e_mispredict, 1);
    chk("beq_target", ex.e_target_pc, 32'h100);
    chk("beq_wr_en", ex.e_gpr_wr_en, 0);
    alu(NE, 32'd9, 32'd9);
    ex.d_branch = 1; ex.d_prediction = 1;
    cyc();
    chk("bne_taken", ex.e_br_j_taken, 0);
    chk("bne_mispred", ex.e_mispredict, 1);
    alu(ADD, 32'd1, 32'd1);
    ex.d_prediction = 1;
    cyc();
    chk("nobr_mispred", ex.e_mispredict, 0);
    chk("nobr_taken", ex.e_br_j_taken, 0);
    alu(ADD, 32'h40, 32'd4);
    ex.d_jump = 1; ex.d_prediction = 1; ex.d_target_pc = 32'h200;
    cyc();
    chk("jal_taken", ex.e_br_j_taken, 1);
    chk("jal_mispred", ex.e_mispredict, 0);
    chk("jal_link", ex.e_result, 32'h44);
    idle_in();
    ex.d_valid = 1; ex.d_mdu_req = 1; ex.d_mdu_operation = 3'd4; ex.d_op1 = 100; ex.d_op2 = 7;
    cyc();
    idle_in();
    repeat (4) cyc();
    arst = 1;
    #1;
    chk("arst_stall", ex.e_stall_req, 0);
    chk("arst_valid", ex.e_valid, 0);
    chk("arst_result", ex.e_result, 0);
    chk("arst_taken", ex.e_br_j_taken, 0);
    chk("arst_target", ex.e_target_pc, 0);
    cyc();
    arst = 0;
    repeat (40) cyc();
    chk("arst_no_result", ex.e_valid, 0);
    chk("arst_idle", ex.e_stall_req, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
